// File: rtl/coproc_pkg.sv
// Shared opcodes, screen geometry and FSM encoding for the zoom coprocessor host interface.
package coproc_pkg;

    localparam logic [2:0] NOP        = 3'b000;
    localparam logic [2:0] LOAD       = 3'b001;
    localparam logic [2:0] STORE      = 3'b010;
    localparam logic [2:0] ZOOM_IN    = 3'b011;
    localparam logic [2:0] ZOOM_OUT   = 3'b100;
    localparam logic [2:0] ZOOM_NN    = 3'b101;
    localparam logic [2:0] ZOOM_AVG   = 3'b110;
    localparam logic [2:0] RESET_INST = 3'b111;

    localparam logic [16:0] SCREEN_PIXELS = 17'd76800;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_STROBE    = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_RST_WAIT  = 3'd5,
        ST_RESPOND   = 3'd6
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bundle of independent asynchronous level signals.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability filter: first stage may go metastable, second stage is used downstream.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/coproc_cmd_issuer.sv
// Host-side initiator: strobes one command onto the coprocessor bus, tracks the
// done handshake across the clock boundary and returns a single response per command.
module coproc_cmd_issuer
    import coproc_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 64,
    parameter int DONE_TIMEOUT = 4194304,
    parameter int RESET_WAIT   = 16,
    parameter int TMR_W        = 23
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_opcode,
    input  logic [16:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_error,
    output logic        rsp_zoom_max,
    output logic        rsp_zoom_min,
    output logic        rsp_timeout,
    output logic [2:0]  co_instruction,
    output logic [7:0]  co_data_in,
    output logic [16:0] co_mem_addr,
    output logic        co_enable,
    input  logic        co_done,
    input  logic        co_error,
    input  logic        co_zoom_max,
    input  logic        co_zoom_min,
    input  logic [7:0]  co_data_out,
    output logic        busy
);

    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] ACK_LAST   = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] DONE_LAST  = TMR_W'(DONE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] RST_LAST   = TMR_W'(RESET_WAIT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX    = {TMR_W{1'b1}};

    state_t state_r, state_nxt_s;

    logic [3:0]       flags_sync_s;
    logic             done_s, error_s, zoom_max_s, zoom_min_s;
    logic             accept_s;

    logic [TMR_W-1:0] timer_r, timer_nxt_s;
    logic             cmd_ready_r, cmd_ready_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             co_enable_r, co_enable_nxt_s;
    logic [2:0]       co_inst_r, co_inst_nxt_s;
    logic [7:0]       co_din_r, co_din_nxt_s;
    logic [16:0]      co_addr_r, co_addr_nxt_s;
    logic             rsp_valid_r, rsp_valid_nxt_s;
    logic [7:0]       rsp_data_r, rsp_data_nxt_s;
    logic             rsp_err_r, rsp_err_nxt_s;
    logic             rsp_zmax_r, rsp_zmax_nxt_s;
    logic             rsp_zmin_r, rsp_zmin_nxt_s;
    logic             rsp_to_r, rsp_to_nxt_s;

    sync_2ff #(.WIDTH(4)) u_flag_sync (
        .clock (clock),
        .reset (reset),
        .d     ({co_done, co_error, co_zoom_max, co_zoom_min}),
        .q     (flags_sync_s)
    );

    assign {done_s, error_s, zoom_max_s, zoom_min_s} = flags_sync_s;
    assign accept_s = cmd_valid && cmd_ready_r && (state_r == ST_IDLE);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an observed done edge wins over a simultaneous timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (cmd_opcode == NOP) begin
                        state_nxt_s = ST_RESPOND;
                    end else begin
                        state_nxt_s = ST_SETUP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (timer_r == SETUP_LAST) begin
                    state_nxt_s = ST_STROBE;
                end else begin
                    state_nxt_s = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (timer_r != PULSE_LAST) begin
                    state_nxt_s = ST_STROBE;
                end else if (co_inst_r == RESET_INST) begin
                    state_nxt_s = ST_RST_WAIT;
                end else begin
                    state_nxt_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (!done_s) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else if (timer_r == ACK_LAST) begin
                    state_nxt_s = ST_RESPOND;
                end else begin
                    state_nxt_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (done_s || (timer_r == DONE_LAST)) begin
                    state_nxt_s = ST_RESPOND;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_RST_WAIT: begin
                if (timer_r == RST_LAST) begin
                    state_nxt_s = ST_RESPOND;
                end else begin
                    state_nxt_s = ST_RST_WAIT;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESPOND;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: next values for every registered output; the bus only changes on accept.
    always_comb begin
        co_inst_nxt_s   = co_inst_r;
        co_din_nxt_s    = co_din_r;
        co_addr_nxt_s   = co_addr_r;
        rsp_data_nxt_s  = rsp_data_r;
        rsp_err_nxt_s   = rsp_err_r;
        rsp_zmax_nxt_s  = rsp_zmax_r;
        rsp_zmin_nxt_s  = rsp_zmin_r;
        rsp_to_nxt_s    = rsp_to_r;
        cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        rsp_valid_nxt_s = (state_nxt_s == ST_RESPOND);
        co_enable_nxt_s = (state_nxt_s != ST_STROBE);

        if (state_nxt_s != state_r) begin
            timer_nxt_s = '0;
        end else if (timer_r == TMR_MAX) begin
            timer_nxt_s = timer_r;
        end else begin
            timer_nxt_s = timer_r + TMR_W'(1);
        end

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    co_inst_nxt_s  = cmd_opcode;
                    co_din_nxt_s   = cmd_data;
                    co_addr_nxt_s  = cmd_addr;
                    rsp_data_nxt_s = 8'h00;
                    rsp_err_nxt_s  = 1'b0;
                    rsp_zmax_nxt_s = 1'b0;
                    rsp_zmin_nxt_s = 1'b0;
                    rsp_to_nxt_s   = 1'b0;
                end else begin
                    rsp_to_nxt_s = rsp_to_r;
                end
            end
            ST_WAIT_ACK: begin
                if (state_nxt_s == ST_RESPOND) begin
                    rsp_to_nxt_s = 1'b1;
                end else begin
                    rsp_to_nxt_s = rsp_to_r;
                end
            end
            ST_WAIT_DONE: begin
                if (done_s) begin
                    rsp_data_nxt_s = co_data_out;
                    rsp_err_nxt_s  = error_s;
                    rsp_zmax_nxt_s = zoom_max_s;
                    rsp_zmin_nxt_s = zoom_min_s;
                end else if (state_nxt_s == ST_RESPOND) begin
                    rsp_to_nxt_s   = 1'b1;
                    rsp_err_nxt_s  = error_s;
                    rsp_zmax_nxt_s = zoom_max_s;
                    rsp_zmin_nxt_s = zoom_min_s;
                end else begin
                    rsp_to_nxt_s = rsp_to_r;
                end
            end
            ST_RST_WAIT: begin
                if (state_nxt_s == ST_RESPOND) begin
                    rsp_err_nxt_s = error_s;
                end else begin
                    rsp_err_nxt_s = rsp_err_r;
                end
            end
            default: begin
                rsp_to_nxt_s = rsp_to_r;
            end
        endcase
    end

    // Output and timer registers; reset drives enable high asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_r     <= '0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            co_enable_r <= 1'b1;
            co_inst_r   <= 3'b000;
            co_din_r    <= 8'h00;
            co_addr_r   <= 17'h00000;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_err_r   <= 1'b0;
            rsp_zmax_r  <= 1'b0;
            rsp_zmin_r  <= 1'b0;
            rsp_to_r    <= 1'b0;
        end else begin
            timer_r     <= timer_nxt_s;
            cmd_ready_r <= cmd_ready_nxt_s;
            busy_r      <= busy_nxt_s;
            co_enable_r <= co_enable_nxt_s;
            co_inst_r   <= co_inst_nxt_s;
            co_din_r    <= co_din_nxt_s;
            co_addr_r   <= co_addr_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            rsp_zmax_r  <= rsp_zmax_nxt_s;
            rsp_zmin_r  <= rsp_zmin_nxt_s;
            rsp_to_r    <= rsp_to_nxt_s;
        end
    end

    assign cmd_ready      = cmd_ready_r;
    assign busy           = busy_r;
    assign co_enable      = co_enable_r;
    assign co_instruction = co_inst_r;
    assign co_data_in     = co_din_r;
    assign co_mem_addr    = co_addr_r;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_data       = rsp_data_r;
    assign rsp_error      = rsp_err_r;
    assign rsp_zoom_max   = rsp_zmax_r;
    assign rsp_zoom_min   = rsp_zmin_r;
    assign rsp_timeout    = rsp_to_r;

endmodule

// File: tb/tb_coproc_cmd_issuer.sv
// Directed bench: a timeline model of each command checked every cycle, plus literal latency pins.
module tb_coproc_cmd_issuer;

    localparam int SETUP = 2;
    localparam int PULSE = 4;
    localparam int ACK_TO = 64;
    localparam int RST_W = 16;
    localparam int SYNC_LAT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [16:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout;
    logic [2:0]  co_instruction;
    logic [7:0]  co_data_in;
    logic [16:0] co_mem_addr;
    logic        co_enable;
    logic        co_done, co_error, co_zoom_max, co_zoom_min;
    logic [7:0]  co_data_out;
    logic        busy;

    coproc_cmd_issuer dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .rsp_zoom_max(rsp_zoom_max), .rsp_zoom_min(rsp_zoom_min),
        .rsp_timeout(rsp_timeout),
        .co_instruction(co_instruction), .co_data_in(co_data_in), .co_mem_addr(co_mem_addr),
        .co_enable(co_enable), .co_done(co_done), .co_error(co_error),
        .co_zoom_max(co_zoom_max), .co_zoom_min(co_zoom_min), .co_data_out(co_data_out),
        .busy(busy)
    );

    initial forever #5 clock = ~clock;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int en_low_cnt = 0;
    int acc_cyc = 0;
    logic check_en = 1'b0;

    // expectation for the next command (kind: 0 NOP, 1 acked, 2 RESET, 3 never acked)
    int e_kind, e_drop, e_raise;
    logic [7:0] e_dout;
    logic [2:0] e_flags;

    // coprocessor model configuration and schedule
    logic cp_nodrop = 1'b1;
    int cp_drop = 0, cp_raise = 0;
    int cp_drop_at = -1, cp_raise_at = -1;
    logic [7:0] cp_dout = 8'h00;
    logic [2:0] cp_flags = 3'b000;

    // timeline model of the command in flight
    int m_A = 0, m_V = 0, m_done_at = 0;
    logic m_strobe = 1'b0;
    logic [2:0] m_op;
    logic [16:0] m_addr;
    logic [7:0] m_data, m_rdata;
    logic m_rerr, m_rzmax, m_rzmin, m_rto;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Coprocessor: on enable rising, drop done after cp_drop cycles and raise it cp_raise later.
    initial begin
        logic en_prev;
        en_prev = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (!en_prev && co_enable && !cp_nodrop) begin
                cp_drop_at  = cyc + cp_drop;
                cp_raise_at = cyc + cp_drop + cp_raise;
            end
            if (cyc == cp_drop_at) begin
                co_done = 1'b0;
                co_data_out = cp_dout;
                {co_error, co_zoom_max, co_zoom_min} = cp_flags;
            end
            if (cyc == cp_raise_at) co_done = 1'b1;
            en_prev = co_enable;
        end
    end

    // Compare process: every cycle, outputs against the timeline model.
    initial begin
        logic in_op, ex_valid, ex_en;
        int r;
        forever begin
            @(negedge clock);
            if (check_en) begin
                in_op    = (cyc >= m_A) && (cyc < m_done_at);
                ex_valid = (cyc >= m_V) && (cyc < m_done_at);
                ex_en    = !(m_strobe && (cyc >= m_A + SETUP) && (cyc < m_A + SETUP + PULSE));
                chk("busy", 32'(busy), 32'(in_op));
                chk("cmd_ready", 32'(cmd_ready), 32'(!in_op));
                chk("rsp_valid", 32'(rsp_valid), 32'(ex_valid));
                chk("co_enable", 32'(co_enable), 32'(ex_en));
                if (in_op)
                    chk("bus_hold", 32'({co_instruction, co_data_in, co_mem_addr}),
                        32'({m_op, m_data, m_addr}));
                if (ex_valid)
                    chk("rsp_fields", 32'({rsp_data, rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout}),
                        32'({m_rdata, m_rerr, m_rzmax, m_rzmin, m_rto}));
                if (!co_enable) en_low_cnt++;
                if (ex_valid && rsp_ready) m_done_at = cyc + 1;
                if (!in_op && cmd_valid) begin
                    m_A = cyc + 1;
                    m_done_at = 32'h7fffffff;
                    m_op = cmd_opcode; m_addr = cmd_addr; m_data = cmd_data;
                    m_strobe = (e_kind != 0);
                    r = m_A + SETUP + PULSE;
                    {m_rdata, m_rerr, m_rzmax, m_rzmin, m_rto} = 12'h000;
                    case (e_kind)
                        0: m_V = m_A;
                        1: begin
                            m_V = r + e_drop + e_raise + SYNC_LAT;
                            m_rdata = e_dout;
                            {m_rerr, m_rzmax, m_rzmin} = e_flags;
                        end
                        2: begin
                            m_V = r + RST_W;
                            m_rerr = co_error;
                        end
                        default: begin
                            m_V = r + ACK_TO;
                            m_rto = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    task automatic start_cmd(input logic [2:0] op, input logic [16:0] addr, input logic [7:0] data,
                             input int kind, input int drop, input int raise_d,
                             input logic [7:0] dout, input logic [2:0] flags);
        e_kind = kind; e_drop = drop; e_raise = raise_d; e_dout = dout; e_flags = flags;
        cp_nodrop = (kind != 1); cp_drop = drop; cp_raise = raise_d;
        cp_dout = dout; cp_flags = flags;
        en_low_cnt = 0;
        @(posedge clock); #1;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_addr = addr; cmd_data = data;
        @(posedge clock); #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic [2:0] op, input logic [16:0] addr,
                           input logic [7:0] data, input int kind, input int drop, input int raise_d,
                           input logic [7:0] dout, input logic [2:0] flags, input int hold,
                           input int lit_lat, input int lit_low, input logic [7:0] lit_data,
                           input logic lit_to);
        logic got;
        start_cmd(op, addr, data, kind, drop, raise_d, dout, flags);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            if (rsp_valid === 1'b1) got = 1'b1;
        end
        chk({name, "_rsp_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({name, "_latency"}, 32'(cyc - acc_cyc), 32'(lit_lat));
            chk({name, "_rsp_data"}, 32'(rsp_data), 32'(lit_data));
            chk({name, "_rsp_timeout"}, 32'(rsp_timeout), 32'(lit_to));
        end
        repeat (hold) @(posedge clock);
        @(posedge clock); #1 rsp_ready = 1'b1;
        @(posedge clock); #1 rsp_ready = 1'b0;
        @(negedge clock);
        chk({name, "_enable_low_cycles"}, 32'(en_low_cnt), 32'(lit_low));
        chk({name, "_back_to_idle"}, 32'({cmd_ready, busy}), 32'b10);
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_opcode = 3'b000; cmd_addr = 17'h00000; cmd_data = 8'h00;
        rsp_ready = 1'b0;
        co_done = 1'b1; co_error = 1'b0; co_zoom_max = 1'b0; co_zoom_min = 1'b0;
        co_data_out = 8'h00;
        e_kind = 0; e_drop = 0; e_raise = 0; e_dout = 8'h00; e_flags = 3'b000;
        m_op = 3'b000; m_addr = 17'h00000; m_data = 8'h00; m_rdata = 8'h00;
        m_rerr = 1'b0; m_rzmax = 1'b0; m_rzmin = 1'b0; m_rto = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_enable", 32'(co_enable), 32'd1);
        chk("rst_valid_busy", 32'({rsp_valid, busy}), 32'd0);
        chk("rst_bus", 32'({co_instruction, co_data_in, co_mem_addr}), 32'd0);
        chk("rst_rsp", 32'({rsp_data, rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout}), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 check_en = 1'b1;

        run_cmd("load", 3'b001, 17'h00123, 8'h00, 1, 3, 20, 8'hA5, 3'b000, 0, 32, 4, 8'hA5, 1'b0);
        run_cmd("nop", 3'b000, 17'h00055, 8'h11, 0, 0, 0, 8'h00, 3'b000, 0, 0, 0, 8'h00, 1'b0);
        run_cmd("store_err", 3'b010, 17'h1FFFF, 8'h7E, 1, 2, 5, 8'h3C, 3'b110, 10, 16, 4, 8'h3C, 1'b0);
        co_error = 1'b1;
        run_cmd("reset_inst", 3'b111, 17'h00000, 8'h00, 2, 0, 0, 8'h00, 3'b000, 0, 22, 4, 8'h00, 1'b0);
        chk("reset_inst_rsp_error_seen", 32'(m_rerr), 32'd1);
        co_error = 1'b0;
        run_cmd("ack_timeout", 3'b100, 17'd76799, 8'h00, 3, 0, 0, 8'h00, 3'b000, 0, 70, 4, 8'h00, 1'b1);

        // reset asserted mid-command while waiting for done to return
        start_cmd(3'b001, 17'h00777, 8'h00, 1, 3, 400, 8'h99, 3'b000);
        repeat (20) @(posedge clock);
        chk("mid_busy_before_reset", 32'(busy), 32'd1);
        #3;
        check_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_enable", 32'(co_enable), 32'd1);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        cp_drop_at = -1; cp_raise_at = -1; co_done = 1'b1;
        m_A = 0; m_done_at = 0; m_strobe = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 check_en = 1'b1;
        run_cmd("load_after_reset", 3'b001, 17'h12C00, 8'h00, 1, 3, 20, 8'h5A, 3'b000, 0, 32, 4, 8'h5A, 1'b0);

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
